prog_timer_ext: RTL and testbench
=================================

Name: prog_timer_ext

Overview:
Parametrised programmable down-counting timer; successor to the fixed 24-bit lab timer.
Adds configurable width, clock prescaler, one-shot/periodic mode, start/stop control and a compare-driven PWM output, while keeping the zero-pulse and toggle (tp) outputs.
Used as the tick/timebase source for display multiplexing, debouncers and blink logic in the lab designs.

Parameters:
WIDTH, 24, bit width of load value, counter and compare
PRESCALE_W, 8, bit width of the prescaler divide value

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
enable  input  1  count enable; 0 pauses the timer in place
start  input  1  single-cycle request to load and run
stop  input  1  single-cycle request to abort and return to idle
mode  input  1  0 = periodic (auto-reload), 1 = one-shot
load_val  input  WIDTH  terminal count in ticks, sampled on start and on each reload
prescale  input  PRESCALE_W  tick = every (prescale+1) enabled clocks, sampled on start and on each prescaler reload
compare  input  WIDTH  PWM threshold
counter  output  WIDTH  current count value
zero  output  1  one-cycle pulse on terminal count
tp  output  1  toggles on every terminal count (half-rate square wave)
pwm  output  1  high while busy and counter <= compare
busy  output  1  high in RUN state

Behaviour:
- Reset (reset=0, async): state=IDLE, counter=0, prescaler count=0, zero=0, tp=0, busy=0; pwm=0.
- States: IDLE, RUN. Two-state FSM; busy = (state==RUN).
- IDLE:
  - start=1 with load_val!=0 -> RUN, counter<=load_val, prescaler<=prescale.
  - start with load_val==0 is ignored.
- RUN, enable=1:
  - Prescaler decrements each clock.
  - When prescaler==0: tick; prescaler<=prescale.
  - On tick with counter>1: counter<=counter-1.
  - On tick with counter==1 (terminal count): zero=1 in the following cycle (registered, exactly one cycle wide) and tp inverts.
    - Periodic: counter<=load_val (current value); stays in RUN.
    - One-shot: counter<=0; next state IDLE.
- RUN, enable=0: counter, prescaler, tp frozen; zero=0; state held.
- Period: terminal count every load_val*(prescale+1) enabled clocks. Prescale=0 gives one decrement per clock.
- start while in RUN (stop=0): restart. Reload counter and prescaler; no zero pulse; tp unchanged. Start is honoured regardless of enable.
- stop=1 (any state): -> IDLE, counter<=0, no zero pulse, tp unchanged. stop wins over a simultaneous start. stop on the terminal-count cycle suppresses that zero pulse and tp toggle.
- load_val/prescale changed mid-run: take effect only at the next reload point; no glitch.
- Periodic reload with load_val==0 at the reload point: counter<=0, -> IDLE (treated as one-shot end).
- pwm: combinational decode of registered state: busy && (counter <= compare). compare=0 gives pwm=0 throughout RUN.
- Arithmetic: unsigned, WIDTH bits. Counter never underflows; minimum loaded value is 1.
- Async reset mid-operation: all outputs go to reset values immediately; first start after release behaves as from power-up.

Decomposition:
- Shared package (timer_pkg):
  - Mode encodings MODE_PERIODIC=1'b0, MODE_ONESHOT=1'b1.
  - FSM state encodings ST_IDLE, ST_RUN.
  - Default WIDTH and PRESCALE_W constants.
- One sub-module, timer_prescaler:
  - Inputs: clk, reset, enable, reload, prescale.
  - Output: tick pulse.
  - Owns the PRESCALE_W down-counter.
- Top: FSM, main counter, zero/tp/pwm registers.

Test Plan:
- WIDTH=24, prescale=0, load_val=5, mode=0, enable=1, start -> zero pulses exactly every 5 clocks; tp toggles with each pulse; counter sequence 5,4,3,2,1,5,...
- prescale=3, load_val=4, mode=0 -> zero every 16 clocks; counter steps every 4 clocks.
- mode=1, load_val=3, prescale=0, start -> single zero pulse 3 clocks after start; busy drops the same cycle counter becomes 0; no further pulses.
- Periodic load_val=10, compare=4 -> pwm high for counter values 4..1 (4 of 10 clocks). Drop enable for 7 cycles mid-run -> counter, tp, pwm frozen; period stretched by exactly 7 clocks.
- stop asserted on the terminal-count cycle -> no zero pulse, tp unchanged, counter=0, busy=0. start+stop in the same cycle -> stays/returns IDLE.
- reset=0 mid-run at counter=123456 (load_val=250000) -> all outputs 0 immediately. After release and start, first zero pulse arrives 250000 clocks later.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared encodings and default sizes for the programmable down-counting timer.
// Imported by the prescaler and the timer top.
package timer_pkg;

  localparam int DEFAULT_WIDTH      = 24;
  localparam int DEFAULT_PRESCALE_W = 8;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage : timer_pkg

// File: rtl/timer_prescaler.sv
// Clock prescaler: emits a one-cycle tick every (prescale+1) enabled clocks.
// The divide value is sampled on reload and each time the count wraps.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  reload,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] count;

  // A reload restarts the division, so it masks any tick in the same cycle.
  assign tick = enable && !reload && (count == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (reload) begin
      count <= prescale;
    end else if (enable) begin
      if (count == '0) count <= prescale;
      else             count <= count - 1'b1;
    end
  end

endmodule : timer_prescaler

// File: rtl/prog_timer_ext.sv
// Programmable down-counting timer with prescaler, one-shot/periodic mode,
// start/stop control, zero pulse, toggle output and compare-driven PWM.
module prog_timer_ext
  import timer_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  mode,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      compare,
  output logic [WIDTH-1:0]      counter,
  output logic                  zero,
  output logic                  tp,
  output logic                  pwm,
  output logic                  busy
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_e state;
  logic   start_ok;
  logic   pre_enable;
  logic   tick;
  logic   reload_ok;

  // A start with a zero terminal count would never reach terminal count.
  assign start_ok   = start && !stop && (load_val != '0);
  assign pre_enable = (state == ST_RUN) && enable && !stop;
  assign reload_ok  = (mode_e'(mode) == MODE_PERIODIC) && (load_val != '0);

  timer_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .enable  (pre_enable),
    .reload  (start_ok),
    .prescale(prescale),
    .tick    (tick)
  );

  // Priority: stop, then (re)start, then counting; a restart never pulses zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      counter <= '0;
      zero    <= 1'b0;
      tp      <= 1'b0;
    end else begin
      zero <= 1'b0;
      if (stop) begin
        state   <= ST_IDLE;
        counter <= '0;
      end else if (start_ok) begin
        state   <= ST_RUN;
        counter <= load_val;
      end else if (state == ST_RUN && enable && tick) begin
        if (counter == CNT_ONE) begin
          zero <= 1'b1;
          tp   <= ~tp;
          if (reload_ok) begin
            counter <= load_val;
          end else begin
            counter <= '0;
            state   <= ST_IDLE;
          end
        end else begin
          counter <= counter - CNT_ONE;
        end
      end
    end
  end

  assign busy = (state == ST_RUN);
  assign pwm  = busy && (counter <= compare);

endmodule : prog_timer_ext

// File: tb/tb_prog_timer_ext.sv
// Directed self-checking bench for prog_timer_ext: periodic/one-shot timing,
// prescaler, PWM, enable freeze, stop/start corner cases and async reset.
module tb_prog_timer_ext;
  import timer_pkg::*;

  localparam int WIDTH = 24;
  localparam int PW    = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             start;
  logic             stop;
  logic             mode;
  logic [WIDTH-1:0] load_val;
  logic [PW-1:0]    prescale;
  logic [WIDTH-1:0] compare;
  logic [WIDTH-1:0] counter;
  logic             zero;
  logic             tp;
  logic             pwm;
  logic             busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  prog_timer_ext #(
    .WIDTH     (WIDTH),
    .PRESCALE_W(PW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .start   (start),
    .stop    (stop),
    .mode    (mode),
    .load_val(load_val),
    .prescale(prescale),
    .compare (compare),
    .counter (counter),
    .zero    (zero),
    .tp      (tp),
    .pwm     (pwm),
    .busy    (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  int first_zero;

  initial begin
    reset    = 1'b0;
    enable   = 1'b1;
    start    = 1'b0;
    stop     = 1'b0;
    mode     = MODE_PERIODIC;
    load_val = '0;
    prescale = '0;
    compare  = '0;

    #1;
    check("rst_counter", 32'(counter), 0);
    check("rst_zero", 32'(zero), 0);
    check("rst_tp", 32'(tp), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_pwm", 32'(pwm), 0);
    repeat (2) step();
    reset = 1'b1;
    step();
    check("idle_busy", 32'(busy), 0);

    // Periodic, load 5, prescale 0: 5,4,3,2,1,5,... with zero every 5 clocks.
    load_val = 24'd5;
    do_start();
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) step();
      check("t1_counter", 32'(counter), 32'(5 - (k % 5)));
      check("t1_zero", 32'(zero), 32'(k > 0 && k % 5 == 0));
      check("t1_pwm_cmp0", 32'(pwm), 0);
    end
    check("t1_tp", 32'(tp), 1);
    do_stop();
    check("t1_stop_busy", 32'(busy), 0);
    check("t1_stop_counter", 32'(counter), 0);
    check("t1_stop_tp", 32'(tp), 1);

    // Prescale 3, load 4: counter steps every 4 clocks, zero every 16.
    load_val = 24'd4;
    prescale = 8'd3;
    do_start();
    for (int k = 0; k <= 17; k++) begin
      if (k > 0) step();
      check("t2_counter", 32'(counter), 32'(4 - ((k / 4) % 4)));
      check("t2_zero", 32'(zero), 32'(k > 0 && k % 16 == 0));
    end
    check("t2_tp", 32'(tp), 0);
    do_stop();

    // One-shot, load 3: single pulse 3 clocks after start, busy drops with it.
    mode     = MODE_ONESHOT;
    load_val = 24'd3;
    prescale = 8'd0;
    do_start();
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) step();
      check("t3_counter", 32'(counter), 32'(k < 3 ? 3 - k : 0));
      check("t3_busy", 32'(busy), 32'(k < 3));
      check("t3_zero", 32'(zero), 32'(k == 3));
    end
    check("t3_tp", 32'(tp), 1);

    // Periodic load 10, compare 4: pwm high for counter 4..1; then 7-cycle freeze.
    mode     = MODE_PERIODIC;
    load_val = 24'd10;
    compare  = 24'd4;
    do_start();
    for (int k = 0; k <= 17; k++) begin
      if (k > 0) step();
      check("t4_counter", 32'(counter), 32'(10 - (k % 10)));
      check("t4_pwm", 32'(pwm), 32'((k % 10) >= 6));
      check("t4_zero", 32'(zero), 32'(k == 10));
    end
    enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      check("t4_frz_counter", 32'(counter), 3);
      check("t4_frz_pwm", 32'(pwm), 1);
      check("t4_frz_tp", 32'(tp), 0);
      check("t4_frz_zero", 32'(zero), 0);
    end
    enable = 1'b1;
    step();
    check("t4_resume_c2", 32'(counter), 2);
    step();
    check("t4_resume_c1", 32'(counter), 1);
    check("t4_resume_nozero", 32'(zero), 0);
    step();
    check("t4_reload", 32'(counter), 10);
    check("t4_late_zero", 32'(zero), 1);
    check("t4_late_tp", 32'(tp), 1);
    do_stop();

    // Stop on the terminal-count cycle suppresses pulse and toggle.
    compare  = 24'd0;
    load_val = 24'd3;
    do_start();
    step();
    step();
    check("t5_pre_counter", 32'(counter), 1);
    do_stop();
    check("t5_counter", 32'(counter), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_zero", 32'(zero), 0);
    check("t5_tp", 32'(tp), 1);
    step();
    check("t5_zero_later", 32'(zero), 0);

    // start+stop together from IDLE and from RUN; start with load 0 ignored.
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("t5_ss_idle_busy", 32'(busy), 0);
    do_start();
    check("t5_run_busy", 32'(busy), 1);
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("t5_ss_run_busy", 32'(busy), 0);
    check("t5_ss_run_counter", 32'(counter), 0);
    load_val = 24'd0;
    do_start();
    check("t5_load0_busy", 32'(busy), 0);
    check("t5_load0_counter", 32'(counter), 0);

    // Periodic reload with load_val cleared mid-run ends like a one-shot.
    load_val = 24'd2;
    do_start();
    load_val = 24'd0;
    step();
    check("t6_counter1", 32'(counter), 1);
    check("t6_busy_run", 32'(busy), 1);
    step();
    check("t6_counter0", 32'(counter), 0);
    check("t6_busy_idle", 32'(busy), 0);
    check("t6_zero", 32'(zero), 1);
    check("t6_tp", 32'(tp), 0);
    step();
    check("t6_zero_once", 32'(zero), 0);

    // Async reset mid-run, then a full period from a fresh start.
    load_val = 24'd20000;
    compare  = 24'd20000;
    do_start();
    repeat (7655) step();
    check("t7_counter_mid", 32'(counter), 12345);
    check("t7_pwm_mid", 32'(pwm), 1);
    #2;
    reset = 1'b0;
    #1;
    check("t7_rst_counter", 32'(counter), 0);
    check("t7_rst_busy", 32'(busy), 0);
    check("t7_rst_pwm", 32'(pwm), 0);
    check("t7_rst_zero", 32'(zero), 0);
    check("t7_rst_tp", 32'(tp), 0);
    step();
    reset = 1'b1;
    step();
    do_start();
    first_zero = -1;
    for (int k = 1; k <= 20005; k++) begin
      step();
      if (zero && first_zero < 0) first_zero = k;
    end
    check("t7_first_zero", 32'(first_zero), 20000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_prog_timer_ext
